// File: rtl/audio_osc_multi_dds.sv
// rtl/audio_osc_multi_dds.sv - time-multiplexed N-channel DDS oscillator with 1st-order delta-sigma DAC
// One channel is evaluated per enabled cycle; the last channel of a frame publishes the mix sample.
module audio_osc_multi_dds #(
  parameter int C_CH      = 4,
  parameter int C_PHASE_W = 24,
  parameter int C_DAC_W   = 12,
  localparam int C_CHA_W  = $clog2(C_CH),
  localparam int C_MIX_W  = 16 + C_CHA_W
) (
  input  logic                 CK_i,
  input  logic                 RST_i,
  input  logic                 EN_CK_i,
  input  logic                 WR_i,
  input  logic [C_CHA_W-1:0]   WR_CH_i,
  input  logic [1:0]           WR_ADR_i,
  input  logic [C_PHASE_W-1:0] WR_DAT_i,
  input  logic                 SYNC_i,
  output logic [C_MIX_W-1:0]   SMPL_o,
  output logic                 SMPL_VLD_o,
  output logic                 DAC_P_o,
  output logic                 DAC_N_o
);

  logic [C_PHASE_W-1:0]       r_phase [C_CH];
  logic [C_PHASE_W-1:0]       r_inc   [C_CH];
  logic [1:0]                 r_mode  [C_CH];
  logic [7:0]                 r_amp   [C_CH];
  logic [7:0]                 r_duty  [C_CH];
  logic [C_CHA_W-1:0]         r_ch_ctr;
  logic signed [C_MIX_W-1:0]  r_acc;
  logic [C_MIX_W-1:0]         r_smpl;
  logic                       r_smpl_vld;
  logic [C_DAC_W-1:0]         r_sigma;
  logic                       r_dac_p;
  logic                       r_dac_n;

  logic [7:0]                 w_t;
  logic [6:0]                 w_u;
  logic [7:0]                 w_wave;
  logic signed [C_MIX_W-1:0]  w_wave_ext;
  logic signed [C_MIX_W-1:0]  w_amp_ext;
  logic signed [C_MIX_W-1:0]  w_term;
  logic                       w_last;
  logic                       w_wr_ok;
  logic [C_PHASE_W+9:0]       w_dat_x;
  logic [C_DAC_W-1:0]         w_d;
  logic [C_DAC_W:0]           w_s;

  assign w_t     = r_phase[r_ch_ctr][C_PHASE_W-1 -: 8];
  assign w_u     = w_t[7] ? ~w_t[6:0] : w_t[6:0];
  assign w_last  = (r_ch_ctr == C_CHA_W'(C_CH - 1));
  assign w_wr_ok = WR_i && (int'(WR_CH_i) < C_CH);
  assign w_dat_x = {10'd0, WR_DAT_i};

  // Waveform values are 8-bit two's complement; tri maps u in 0..127 to 2u-128.
  always_comb begin
    w_wave = 8'h00;
    case (r_mode[r_ch_ctr])
      2'd0:    w_wave = {~w_t[7], w_t[6:0]};
      2'd1:    w_wave = (w_t < r_duty[r_ch_ctr]) ? 8'h7F : 8'h80;
      2'd2:    w_wave = {~w_u[6], w_u[5:0], 1'b0};
      default: w_wave = 8'h00;
    endcase
  end

  assign w_wave_ext = {{(C_MIX_W-8){w_wave[7]}}, w_wave};
  assign w_amp_ext  = {{(C_MIX_W-8){1'b0}}, r_amp[r_ch_ctr]};
  assign w_term     = w_wave_ext * w_amp_ext;

  // Offset-binary view of the mix: flipping the sign bit biases it to unsigned.
  assign w_d = {~r_smpl[C_MIX_W-1], r_smpl[C_MIX_W-2 -: C_DAC_W-1]};
  assign w_s = {1'b0, r_sigma} + {1'b0, w_d};

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      for (int i = 0; i < C_CH; i++) begin
        r_phase[i] <= '0;
        r_inc[i]   <= '0;
        r_mode[i]  <= 2'd3;
        r_amp[i]   <= '0;
        r_duty[i]  <= 8'd128;
      end
      r_ch_ctr   <= '0;
      r_acc      <= '0;
      r_smpl     <= '0;
      r_smpl_vld <= 1'b0;
      r_sigma    <= '0;
      r_dac_p    <= 1'b0;
      r_dac_n    <= 1'b0;
    end else begin
      r_sigma    <= w_s[C_DAC_W-1:0];
      r_dac_p    <= w_s[C_DAC_W];
      r_dac_n    <= ~w_s[C_DAC_W];
      r_smpl_vld <= 1'b0;
      if (SYNC_i) begin
        for (int i = 0; i < C_CH; i++) r_phase[i] <= '0;
        r_acc    <= '0;
        r_ch_ctr <= '0;
      end else if (EN_CK_i) begin
        r_phase[r_ch_ctr] <= r_phase[r_ch_ctr] + r_inc[r_ch_ctr];
        if (w_last) begin
          r_smpl     <= r_acc + w_term;
          r_acc      <= '0;
          r_ch_ctr   <= '0;
          r_smpl_vld <= 1'b1;
        end else begin
          r_acc    <= r_acc + w_term;
          r_ch_ctr <= r_ch_ctr + C_CHA_W'(1);
        end
      end
      // Register writes never touch the phase, so they coexist with the slot above.
      if (w_wr_ok) begin
        case (WR_ADR_i)
          2'd0: r_inc[WR_CH_i] <= WR_DAT_i;
          2'd1: begin
            r_mode[WR_CH_i] <= w_dat_x[1:0];
            r_amp[WR_CH_i]  <= w_dat_x[9:2];
          end
          2'd2: r_duty[WR_CH_i] <= w_dat_x[7:0];
          default: ;
        endcase
      end
    end
  end

  assign SMPL_o     = r_smpl;
  assign SMPL_VLD_o = r_smpl_vld;
  assign DAC_P_o    = r_dac_p;
  assign DAC_N_o    = r_dac_n;

endmodule

// File: tb/tb_audio_osc_multi_dds.sv
// tb/tb_audio_osc_multi_dds.sv - directed bench with an arithmetic reference model of the oscillator
module tb_audio_osc_multi_dds;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        wr = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [1:0]  wr_adr = '0;
  logic [23:0] wr_dat = '0;
  logic        sync = 1'b0;
  logic [17:0] smpl;
  logic        smpl_vld;
  logic        dac_p;
  logic        dac_n;

  int tests = 0;
  int fails = 0;
  int printed = 0;

  audio_osc_multi_dds dut (
    .CK_i(clk), .RST_i(rst), .EN_CK_i(en), .WR_i(wr), .WR_CH_i(wr_ch),
    .WR_ADR_i(wr_adr), .WR_DAT_i(wr_dat), .SYNC_i(sync),
    .SMPL_o(smpl), .SMPL_VLD_o(smpl_vld), .DAC_P_o(dac_p), .DAC_N_o(dac_n)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the architectural state.
  int m_phase [NCH];
  int m_inc [NCH];
  int m_mode [NCH];
  int m_amp [NCH];
  int m_duty [NCH];
  int m_ch, m_acc, m_smpl, m_sigma;
  bit m_vld, m_p, m_n;
  bit model_on = 1'b0;

  function automatic int wave(int mode, int t, int duty);
    case (mode)
      0: return t - 128;
      1: return (t < duty) ? 127 : -128;
      2: return (t < 128) ? (2 * t - 128) : (2 * (255 - t) - 128);
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_phase[i] = 0; m_inc[i] = 0; m_mode[i] = 3; m_amp[i] = 0; m_duty[i] = 128;
      end
      m_ch = 0; m_acc = 0; m_smpl = 0; m_sigma = 0;
      m_vld = 0; m_p = 0; m_n = 0;
      model_on = 1'b1;
    end else begin
      int d, s, t, term;
      d = (m_smpl + 131072) / 64;
      s = m_sigma + d;
      m_p = (s >= 4096);
      m_n = !m_p;
      m_sigma = s % 4096;
      m_vld = 0;
      if (sync) begin
        for (int i = 0; i < NCH; i++) m_phase[i] = 0;
        m_acc = 0; m_ch = 0;
      end else if (en) begin
        t = m_phase[m_ch] / 65536;
        term = wave(m_mode[m_ch], t, m_duty[m_ch]) * m_amp[m_ch];
        m_phase[m_ch] = (m_phase[m_ch] + m_inc[m_ch]) % 16777216;
        if (m_ch == NCH - 1) begin
          m_smpl = m_acc + term; m_acc = 0; m_ch = 0; m_vld = 1;
        end else begin
          m_acc = m_acc + term; m_ch = m_ch + 1;
        end
      end
      if (wr && int'(wr_ch) < NCH) begin
        case (wr_adr)
          2'd0: m_inc[wr_ch] = int'(wr_dat);
          2'd1: begin m_mode[wr_ch] = int'(wr_dat) % 4; m_amp[wr_ch] = (int'(wr_dat) / 4) % 256; end
          2'd2: m_duty[wr_ch] = int'(wr_dat) % 256;
          default: ;
        endcase
      end
    end
  end

  task automatic note_fail(string name, int act, int exp);
    fails++;
    if (printed < 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    printed++;
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      tests += 4;
      if (smpl_vld !== m_vld) note_fail("model vld", int'(smpl_vld), int'(m_vld));
      if ($signed(smpl) !== m_smpl) note_fail("model smpl", $signed(smpl), m_smpl);
      if (dac_p !== m_p) note_fail("model dac_p", int'(dac_p), int'(m_p));
      if (dac_n !== m_n) note_fail("model dac_n", int'(dac_n), int'(m_n));
    end
  end

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) note_fail(name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(int ch, int adr, int dat);
    wr = 1'b1; wr_ch = 2'(ch); wr_adr = 2'(adr); wr_dat = 24'(dat);
    tick;
    wr = 1'b0;
  endtask

  task automatic do_sync;
    sync = 1'b1; tick; sync = 1'b0;
  endtask

  task automatic wait_vld(output int v, output int n);
    n = 0; v = 0;
    do begin @(negedge clk); n++; end while (!smpl_vld && n < 64);
    if (!smpl_vld) begin tests++; note_fail("vld timeout", n, 64); end
    else v = $signed(smpl);
  endtask

  task automatic count_ones(int cycles, output int ones);
    ones = 0;
    for (int i = 0; i < cycles; i++) begin @(negedge clk); if (dac_p) ones++; end
  endtask

  initial begin
    int v, n, ones, held;
    int frames [$];
    tick; tick;
    chk("reset smpl", $signed(smpl), 0);
    chk("reset vld", int'(smpl_vld), 0);
    chk("reset dac_p", int'(dac_p), 0);
    chk("reset dac_n", int'(dac_n), 0);
    rst = 1'b0;

    wait_vld(v, n);
    chk("first vld latency", n, 5);
    chk("idle smpl", v, 0);
    wait_vld(v, n);
    chk("idle frame period", n, 4);
    count_ones(8, ones);
    chk("idle dac density", ones, 4);

    // Saw on ch0, amp 128.
    wr_reg(0, 0, 24'h010000);
    wr_reg(0, 1, (128 << 2) | 0);
    do_sync;
    frames.delete();
    for (int i = 0; i < 257; i++) begin wait_vld(v, n); frames.push_back(v); end
    chk("saw f0", frames[0], -16384);
    chk("saw f1", frames[1], -16256);
    chk("saw f255", frames[255], 16256);
    chk("saw wrap", frames[256], -16384);

    // Pulse duty 64, amp 255.
    wr_reg(0, 1, (255 << 2) | 1);
    wr_reg(0, 2, 64);
    do_sync;
    frames.delete();
    for (int i = 0; i < 65; i++) begin wait_vld(v, n); frames.push_back(v); end
    chk("pulse f0", frames[0], 32385);
    chk("pulse f63", frames[63], 32385);
    chk("pulse f64", frames[64], -32640);
    wr_reg(0, 2, 0);
    do_sync;
    wait_vld(v, n);
    chk("pulse duty0", v, -32640);

    // Triangle, amp 1.
    wr_reg(0, 1, (1 << 2) | 2);
    do_sync;
    frames.delete();
    for (int i = 0; i < 256; i++) begin wait_vld(v, n); frames.push_back(v); end
    chk("tri t0", frames[0], -128);
    chk("tri t127", frames[127], 126);
    chk("tri t128", frames[128], 126);
    chk("tri t255", frames[255], -128);

    // All channels full-scale.
    wr_reg(0, 0, 0);
    for (int c = 0; c < NCH; c++) begin wr_reg(c, 1, (255 << 2) | 1); wr_reg(c, 2, 255); end
    do_sync;
    wait_vld(v, n);
    chk("mix max", v, 129540);
    count_ones(4096, ones);
    chk("dac density max", ones, 4072);
    for (int c = 0; c < NCH; c++) wr_reg(c, 1, (255 << 2) | 0);
    do_sync;
    wait_vld(v, n);
    chk("mix min", v, -130560);
    count_ones(4096, ones);
    chk("dac density min", ones, 8);

    // SYNC at slot 2.
    for (int c = 0; c < NCH; c++) wr_reg(c, 1, 3);
    wr_reg(0, 0, 24'h010000);
    wr_reg(0, 1, (128 << 2) | 0);
    do_sync;
    for (int i = 0; i < 3; i++) wait_vld(v, n);
    chk("pre-sync saw f2", v, -16128);
    tick; tick;
    do_sync;
    wait_vld(v, n);
    chk("sync restart latency", n, 5);
    chk("sync restart t0", v, -16384);

    // Write to ch1 inc during its own slot.
    wr_reg(0, 1, 3);
    wr_reg(1, 1, (1 << 2) | 0);
    do_sync;
    wait_vld(v, n);
    chk("ch1 saw t0", v, -128);
    tick;
    wr_reg(1, 0, 24'h800000);
    wait_vld(v, n);
    chk("wr frame", v, -128);
    wait_vld(v, n);
    chk("old inc used", v, -128);
    wait_vld(v, n);
    chk("new inc used", v, 0);

    // EN_CK_i low for 10 cycles mid-frame.
    tick;
    en = 1'b0;
    held = $signed(smpl);
    for (int i = 0; i < 10; i++) tick;
    chk("freeze smpl", $signed(smpl), held);
    en = 1'b1;
    wait_vld(v, n);
    chk("resume frame", v, -128);
    chk("resume latency", n, 4);

    // Reset mid-frame.
    tick;
    rst = 1'b1; tick; rst = 1'b0;
    chk("midreset smpl", $signed(smpl), 0);
    wait_vld(v, n);
    chk("midreset latency", n, 5);
    chk("midreset mix", v, 0);

    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1);
  end

endmodule
